// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: ALU control codes shared with the decoder, FSM encoding and iteration count
package alu_exec_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_MUL = 4'b0101;
    localparam logic [3:0] ALU_DIV = 4'b1011;
    localparam logic [5:0] ITER_N  = 6'd32;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: 32-step shift-add multiplier and (with ALU_EXEC_DIV_EN) restoring divider
module alu_iter_muldiv
    import alu_exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] result
);
    logic        run;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [63:0] acc_n;
    logic [31:0] opd;
    logic [32:0] sum;
    logic [63:0] acc_ld;
    logic [31:0] opd_ld;
    assign done = run && (cnt == ITER_N - 6'd1);
`ifdef ALU_EXEC_DIV_EN
    logic        neg;
    logic        op_q;
    logic [63:0] sh;
    logic [32:0] diff;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    assign a_mag  = a[31] ? -a : a;
    assign b_mag  = b[31] ? -b : b;
    assign acc_ld = {32'd0, op ? a_mag : a};
    assign opd_ld = op ? b_mag : b;
    // one iteration: add-and-shift for MUL, shift-and-trial-subtract for DIV
    always_comb begin
        sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
        sh    = {acc[62:0], 1'b0};
        diff  = {1'b0, sh[63:32]} - {1'b0, opd};
        acc_n = op_q ? (diff[32] ? sh : {diff[31:0], sh[31:1], 1'b1}) : {sum, acc[31:1]};
    end
    // the quotient sign is fixed up on the last step so the result is ready with done
    assign result = (op_q && neg) ? -acc_n[31:0] : acc_n[31:0];
    // remember operation and quotient sign for the whole sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg  <= 1'b0;
            op_q <= 1'b0;
        end else if (start) begin
            neg  <= a[31] ^ b[31];
            op_q <= op;
        end
    end
`else
    logic unused_op;
    assign unused_op = op;
    assign acc_ld    = {32'd0, a};
    assign opd_ld    = b;
    // one multiply iteration: conditional add of the multiplicand, then shift right
    always_comb begin
        sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
        acc_n = {sum, acc[31:1]};
    end
    assign result = acc_n[31:0];
`endif
    // iteration counter and accumulator; low product bits are the signed low product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            acc <= '0;
            opd <= '0;
        end else if (flush) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            acc <= acc_ld;
            opd <= opd_ld;
        end else if (run) begin
            run <= !done;
            cnt <= cnt + 6'd1;
            acc <= acc_n;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with handshake; ALU_EXEC_DIV_EN builds the iterative divider
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    input  logic             Flush,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Busy
);
    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             is_mul;
    logic             div_go;
    logic             div_z;
    logic             iter_start;
    logic             iter_done;
    logic             fire;
    logic [WIDTH-1:0] iter_res;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] res_d;
    assign In_Ready   = (state_q == ST_IDLE);
    assign Busy       = ~In_Ready;
    assign accept     = In_Valid && In_Ready && !Flush;
    assign is_mul     = (ALU_Control == ALU_MUL);
`ifdef ALU_EXEC_DIV_EN
    assign div_go     = (ALU_Control == ALU_DIV) && (B != '0);
    assign div_z      = (ALU_Control == ALU_DIV) && (B == '0);
`else
    assign div_go     = 1'b0;
    assign div_z      = 1'b0;
`endif
    assign iter_start = accept && (is_mul || div_go);
    assign fire       = (accept && !iter_start) || (iter_done && !Flush);
    assign res_d      = iter_done ? iter_res : sc_res;
    alu_iter_muldiv u_iter (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .start  (iter_start),
        .op     (div_go),
        .flush  (Flush),
        .a      (A),
        .b      (B),
        .done   (iter_done),
        .result (iter_res)
    );
    // single-cycle datapath; divide-by-zero resolves here without iterating
    always_comb begin
        case (ALU_Control)
            ALU_AND: sc_res = A & B;
            ALU_OR:  sc_res = A | B;
            ALU_ADD: sc_res = A + B;
            ALU_SUB: sc_res = A - B;
            ALU_NOR: sc_res = ~(A | B);
            ALU_XOR: sc_res = A ^ B;
            ALU_SLT: sc_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLL: sc_res = B << Shamt;
            ALU_SRL: sc_res = B >> Shamt;
            ALU_SRA: sc_res = $signed(B) >>> Shamt;
            ALU_DIV: sc_res = {WIDTH{div_z}};
            default: sc_res = '0;
        endcase
    end
    // next state: flush wins, then accept of an iterative op, then completion
    always_comb begin
        state_d = state_q;
        if (Flush)
            state_d = ST_IDLE;
        else if (iter_start)
            state_d = is_mul ? ST_MUL : ST_DIV;
        else if (iter_done)
            state_d = ST_IDLE;
    end
    // state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end
    // output registers; Result and Zero only move with Out_Valid
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_Valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b1;
        end else begin
            Out_Valid <= fire;
            if (fire) begin
                Result <= res_d;
                Zero   <= (res_d == '0);
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
    import alu_exec_pkg::*;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [3:0]  ALU_Control = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [4:0]  Shamt = 5'd0;
    logic        Flush = 1'b0;
    logic        Out_Valid;
    logic [31:0] Result;
    logic        Zero;
    logic        Busy;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  s;
        logic [31:0] e;
    } vec_t;

    always #5 Clk = ~Clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .ALU_Control (ALU_Control),
        .A           (A),
        .B           (B),
        .Shamt       (Shamt),
        .Flush       (Flush),
        .Out_Valid   (Out_Valid),
        .Result      (Result),
        .Zero        (Zero),
        .Busy        (Busy)
    );

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s);
        In_Valid = v;
        ALU_Control = c;
        A = a;
        B = b;
        Shamt = s;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", Out_Valid); end
        total++; if (Result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", Result); end
        total++; if (Zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", Zero); end
        total++; if (In_Ready !== 1'b1 || Busy !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b exp=1/0", In_Ready, Busy); end
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_back_to_back;
        vec_t v[4];
        v[0] = '{ALU_ADD, 32'd5, 32'd7, 5'd0, 32'd12};
        v[1] = '{ALU_SUB, 32'd3, 32'd3, 5'd0, 32'd0};
        v[2] = '{ALU_SLT, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1};
        v[3] = '{ALU_SRA, 32'd0, 32'h80000000, 5'd4, 32'hF8000000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, v[i].c, v[i].a, v[i].b, v[i].s);
            @(negedge Clk);
            total++;
            if (Out_Valid !== 1'b1 || Result !== v[i].e || Zero !== (v[i].e == 32'd0) || In_Ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_%0d got ov=%b res=%h z=%b rdy=%b exp ov=1 res=%h z=%b rdy=1",
                         i, Out_Valid, Result, Zero, In_Ready, v[i].e, v[i].e == 32'd0);
            end
        end
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        @(negedge Clk);
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_ov got=%b exp=0", Out_Valid); end
    endtask

    task automatic test_single_cycle;
        vec_t v[9];
        v[0] = '{ALU_AND, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 32'h00F0F000};
        v[1] = '{ALU_OR,  32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 32'hFFF0FFF0};
        v[2] = '{ALU_XOR, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 32'hFF000FF0};
        v[3] = '{ALU_NOR, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 32'h000F000F};
        v[4] = '{ALU_SLL, 32'd0, 32'h80000001, 5'd1, 32'h00000002};
        v[5] = '{ALU_SRL, 32'd0, 32'h80000000, 5'd4, 32'h08000000};
        v[6] = '{ALU_ADD, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd1};
        v[7] = '{ALU_SLT, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0};
        v[8] = '{4'b0011, 32'd5, 32'd7, 5'd0, 32'd0};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, v[i].c, v[i].a, v[i].b, v[i].s);
            @(negedge Clk);
            total++;
            if (Out_Valid !== 1'b1 || Result !== v[i].e || Zero !== (v[i].e == 32'd0)) begin
                bad++;
                $display("FAIL single_%0d got ov=%b res=%h z=%b exp ov=1 res=%h z=%b",
                         i, Out_Valid, Result, Zero, v[i].e, v[i].e == 32'd0);
            end
        end
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        @(negedge Clk);
    endtask

    task automatic test_mul;
        int busy_bad;
        drive(1'b1, ALU_MUL, 32'hFFFFFFFD, 32'd7, 5'd0);
        @(negedge Clk);
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        busy_bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (In_Ready !== 1'b0 || Busy !== 1'b1 || Out_Valid !== 1'b0) busy_bad++;
            @(negedge Clk);
        end
        total++; if (busy_bad != 0) begin bad++; $display("FAIL mul_busy_window bad_cycles=%0d exp=0", busy_bad); end
        total++;
        if (Out_Valid !== 1'b1 || Result !== 32'hFFFFFFEB || In_Ready !== 1'b1 || Zero !== 1'b0) begin
            bad++;
            $display("FAIL mul_result got ov=%b res=%h rdy=%b z=%b exp ov=1 res=ffffffeb rdy=1 z=0", Out_Valid, Result, In_Ready, Zero);
        end
        drive(1'b1, ALU_ADD, 32'd1, 32'd2, 5'd0);
        @(negedge Clk);
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        total++; if (Out_Valid !== 1'b1 || Result !== 32'd3) begin bad++; $display("FAIL mul_then_add got ov=%b res=%h exp ov=1 res=3", Out_Valid, Result); end
        @(negedge Clk);
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL mul_pulse_width got=%b exp=0", Out_Valid); end
    endtask

`ifdef ALU_EXEC_DIV_EN
    task automatic test_div;
        vec_t v[2];
        int n;
        v[0] = '{ALU_DIV, 32'hFFFFFFF9, 32'd2, 5'd0, 32'hFFFFFFFD};
        v[1] = '{ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, v[i].c, v[i].a, v[i].b, 5'd0);
            @(negedge Clk);
            drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
            n = 1;
            while (Out_Valid !== 1'b1 && n < 40) begin
                @(negedge Clk);
                n++;
            end
            total++; if (n != 33) begin bad++; $display("FAIL div_%0d_latency got=%0d exp=33", i, n); end
            total++; if (Result !== v[i].e) begin bad++; $display("FAIL div_%0d_result got=%h exp=%h", i, Result, v[i].e); end
            @(negedge Clk);
        end
        drive(1'b1, ALU_DIV, 32'd9, 32'd0, 5'd0);
        @(negedge Clk);
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        total++;
        if (Out_Valid !== 1'b1 || Result !== 32'hFFFFFFFF || In_Ready !== 1'b1) begin
            bad++;
            $display("FAIL div_by_zero got ov=%b res=%h rdy=%b exp ov=1 res=ffffffff rdy=1", Out_Valid, Result, In_Ready);
        end
        @(negedge Clk);
    endtask
`else
    task automatic test_div_disabled;
        drive(1'b1, ALU_DIV, 32'd9, 32'd3, 5'd0);
        @(negedge Clk);
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        total++;
        if (Out_Valid !== 1'b1 || Result !== 32'd0 || Zero !== 1'b1 || In_Ready !== 1'b1) begin
            bad++;
            $display("FAIL div_disabled got ov=%b res=%h z=%b rdy=%b exp ov=1 res=0 z=1 rdy=1", Out_Valid, Result, Zero, In_Ready);
        end
        drive(1'b1, ALU_DIV, 32'd9, 32'd0, 5'd0);
        @(negedge Clk);
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        total++; if (Out_Valid !== 1'b1 || Result !== 32'd0 || In_Ready !== 1'b1) begin bad++; $display("FAIL div_disabled_zero got ov=%b res=%h rdy=%b exp ov=1 res=0 rdy=1", Out_Valid, Result, In_Ready); end
        @(negedge Clk);
    endtask
`endif

    task automatic test_flush;
        int leak;
        logic [3:0] iter_code;
`ifdef ALU_EXEC_DIV_EN
        iter_code = ALU_DIV;
`else
        iter_code = ALU_MUL;
`endif
        drive(1'b1, ALU_ADD, 32'd10, 32'd20, 5'd0);
        @(negedge Clk);
        total++; if (Result !== 32'd30) begin bad++; $display("FAIL flush_setup got=%h exp=1e", Result); end
        drive(1'b1, iter_code, 32'd100, 32'd3, 5'd0);
        @(negedge Clk);
        drive(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd0);
        leak = 0;
        repeat (4) begin
            if (Out_Valid !== 1'b0 || In_Ready !== 1'b0) leak++;
            @(negedge Clk);
        end
        total++; if (leak != 0) begin bad++; $display("FAIL flush_held_valid bad_cycles=%0d exp=0", leak); end
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        total++;
        if (In_Ready !== 1'b1 || Busy !== 1'b0 || Out_Valid !== 1'b0 || Result !== 32'd30) begin
            bad++;
            $display("FAIL flush_abort got rdy=%b busy=%b ov=%b res=%h exp rdy=1 busy=0 ov=0 res=1e", In_Ready, Busy, Out_Valid, Result);
        end
        leak = 0;
        repeat (35) begin
            @(negedge Clk);
            if (Out_Valid !== 1'b0) leak++;
        end
        total++; if (leak != 0 || Result !== 32'd30) begin bad++; $display("FAIL flush_no_late_valid pulses=%0d res=%h exp 0 and 1e", leak, Result); end
        drive(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd0);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        total++; if (Out_Valid !== 1'b0 || Result !== 32'd30) begin bad++; $display("FAIL flush_cancel_single got ov=%b res=%h exp ov=0 res=1e", Out_Valid, Result); end
        drive(1'b1, ALU_MUL, 32'd2, 32'd2, 5'd0);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        total++; if (In_Ready !== 1'b1 || Out_Valid !== 1'b0) begin bad++; $display("FAIL flush_cancel_mul got rdy=%b ov=%b exp rdy=1 ov=0", In_Ready, Out_Valid); end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid;
        int leak;
        drive(1'b1, ALU_MUL, 32'hFFFFFFFD, 32'd7, 5'd0);
        @(negedge Clk);
        drive(1'b0, ALU_AND, 32'd0, 32'd0, 5'd0);
        repeat (9) @(negedge Clk);
        total++; if (In_Ready !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", In_Ready); end
        Reset_n = 1'b0;
        #1;
        total++;
        if (Result !== 32'd0 || Zero !== 1'b1 || In_Ready !== 1'b1 || Busy !== 1'b0 || Out_Valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_state got res=%h z=%b rdy=%b busy=%b ov=%b exp res=0 z=1 rdy=1 busy=0 ov=0", Result, Zero, In_Ready, Busy, Out_Valid);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        leak = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Out_Valid !== 1'b0) leak++;
        end
        total++; if (leak != 0 || Result !== 32'd0 || In_Ready !== 1'b1) begin bad++; $display("FAIL rst_mid_after pulses=%0d res=%h rdy=%b exp 0/0/1", leak, Result, In_Ready); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_cycle();
        test_mul();
`ifdef ALU_EXEC_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two 32-bit operands. Logical, arithmetic, compare and shift operations complete in one cycle; MUL and DIV run as 32-step iterative sequences and hold off new issue through a ready/valid handshake. The unit sits between the ID/EX pipeline register and the EX/MEM register; the hazard unit stalls on `In_Ready` low.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `Clk`  in  1  single clock, rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `In_Valid`  in  1  operands and code are valid this cycle.
- `In_Ready`  out  1  unit can accept; an operation is accepted when `In_Valid & In_Ready`.
- `ALU_Control`  in  4  operation code (see Operation).
- `A`  in  32  operand A (rs).
- `B`  in  32  operand B (rt or immediate).
- `Shamt`  in  5  shift amount.
- `Flush`  in  1  synchronous abort of any operation in progress.
- `Out_Valid`  out  1  one-cycle pulse: `Result`/`Zero` are valid.
- `Result`  out  32  registered result; holds its value until the next `Out_Valid`.
- `Zero`  out  1  registered, `Result == 0`.
- `Busy`  out  1  iterative operation in progress (`~In_Ready`).

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0100 XOR, 0111 SLT (signed, result 1/0), 1000 SLL (B << Shamt), 1001 SRL, 1010 SRA (B arithmetic >> Shamt), 0101 MUL, 1011 DIV. Any other code yields `Result` = 0 in one cycle.
- ADD/SUB wrap modulo 2^32; no overflow trap.
- MUL: signed product, low 32 bits returned, shift-add on a 64-bit accumulator.
- DIV: signed quotient truncated toward zero, computed as restoring division on magnitudes; sign correction is applied in the final iteration. 0x80000000 / 0xFFFFFFFF returns 0x80000000.
- Divide by zero is detected at accept and returns 0xFFFFFFFF with single-cycle latency.
- State machine: IDLE, MUL, DIV.
  - IDLE to MUL or DIV on accept of the matching code.
  - MUL/DIV return to IDLE when the 6-bit iteration counter reaches 32, or on `Flush`.
- `In_Valid` is ignored while `In_Ready` is low. There is no queueing; the issuer must hold the instruction.
- `Flush`:
  - Returns the unit to IDLE next cycle.
  - Suppresses `Out_Valid` for the aborted operation.
  - `Result` keeps its previous value.
  - A `Flush` in the same cycle as an accept cancels that accept.
- Reset (any time, including mid-iteration):
  - State goes to IDLE and the counter and accumulators clear.
  - Outputs after reset: `Out_Valid`=0, `Result`=0, `Zero`=1, `In_Ready`=1, `Busy`=0.

## Timing
- Accept in cycle T.
- Single-cycle ops and divide-by-zero: `Out_Valid` and `Result` at T+1. `In_Ready` stays high, so back-to-back issue gives one result per cycle.
- MUL/DIV:
  - `In_Ready` is low from T+1 through T+32.
  - `Out_Valid` pulses at T+33 with `In_Ready` high in the same cycle.
  - A new accept at T+33 is allowed.
- `Zero` updates in the same cycle as `Result`.

## Configuration
- `ALU_EXEC_DIV_EN` defined: the iterative divider is built and code 1011 behaves as specified.
- Not defined:
  - Divider logic is omitted.
  - Code 1011 returns 0 with single-cycle latency and never deasserts `In_Ready`.
  - MUL is unaffected.

## Structure
- Package `alu_exec_pkg`:
  - localparams for all 12 ALU codes, shared with the ALU control decoder.
  - state encoding for IDLE/MUL/DIV.
  - iteration count constant 32.
- Sub-module `alu_iter_muldiv`:
  - contains the counter, 64-bit accumulator and sign-fix logic.
  - start/op/done interface.
  - divider portion guarded by `ALU_EXEC_DIV_EN`.
- The top level holds the single-cycle datapath, the handshake and the output registers.

## Test plan
- Reset asserted mid-MUL at T+10 -> `Result`=0, `Zero`=1, `In_Ready`=1; there is no `Out_Valid` after release.
- Back-to-back ADD 5+7, SUB 3-3, SLT -1<1, SRA 0x80000000 by 4 -> `Out_Valid` on 4 consecutive cycles with 12, 0 (`Zero`=1), 1, 0xF8000000.
- MUL 0xFFFFFFFD × 7 accepted at T -> `In_Ready` low T+1..T+32; `Out_Valid` at T+33 with 0xFFFFFFEB; a new ADD accepted at T+33 completes at T+34.
- DIV -7 / 2 -> 0xFFFFFFFD at T+33; DIV 0x80000000 / -1 -> 0x80000000.
- DIV 9 / 0 -> 0xFFFFFFFF at T+1; with `ALU_EXEC_DIV_EN` undefined, DIV 9 / 3 -> 0 at T+1.
- `Flush` at T+5 during DIV -> IDLE at T+6, no `Out_Valid`, `Result` unchanged; `In_Valid` held during busy cycles is not accepted.
